// File: rtl/pipeline_skid_stage_if.sv
// Valid/ready bus for one elastic pipeline boundary: upstream (in_*) and downstream (out_*) sides.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1; valid never waits on ready.
interface pipeline_skid_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipeline_skid_stage.sv
// Elastic two-entry pipeline register with registered in_ready, synchronous flush and bubble masking.
// o_count doubles as the exposed FSM state (0 EMPTY, 1 ONE, 2 TWO).
module pipeline_skid_stage #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    pipeline_skid_stage_if.slave bus,
    output logic [1:0]           o_count
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_in_fire;
    logic w_out_fire;
    logic w_out_valid;
    logic w_load_main;
    logic w_main_from_skid;
    logic w_load_skid;

    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = w_out_valid & bus.out_ready;

    // State register; in_ready stays low during reset and rises on the first clocked edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_TWO);
        end
    end

    // Next-state and datapath steering; flush overrides everything, discarding any in_fire.
    always_comb begin
        w_next_state     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_load_main  = 1'b1;
                        w_next_state = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main = 1'b1;
                    end else if (w_in_fire) begin
                        w_load_skid  = 1'b1;
                        w_next_state = ST_TWO;
                    end else if (w_out_fire) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_next_state     = ST_ONE;
                    end
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    // Payload registers carry no reset; out_data is masked while no entry is live.
    always_ff @(posedge i_clk) begin
        if (w_load_main) r_main <= w_main_from_skid ? r_skid : bus.in_data;
        if (w_load_skid) r_skid <= bus.in_data;
    end

    always_comb begin
        w_out_valid  = (r_state != ST_EMPTY);
        bus.out_data = w_out_valid ? r_main : BUBBLE_VALUE;
        bus.in_ready = r_in_ready;
        o_count      = r_state;
    end

    assign bus.out_valid = w_out_valid;
endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Directed and randomized checks of pipeline_skid_stage against a queue-based occupancy/ordering model.
module tb_pipeline_skid_stage;
    logic clk;
    logic rst_n;
    logic flush8;
    logic flush37;
    logic [1:0] cnt8;
    logic [1:0] cnt37;
    bit sel37;

    int checks = 0;
    int errors = 0;

    pipeline_skid_stage_if #(.WIDTH(8))  if8 ();
    pipeline_skid_stage_if #(.WIDTH(37)) if37 ();

    pipeline_skid_stage #(.WIDTH(8), .BUBBLE_VALUE(8'hA5)) dut8 (
        .i_clk(clk), .i_rst(rst_n), .i_flush(flush8), .bus(if8), .o_count(cnt8)
    );

    pipeline_skid_stage #(.WIDTH(37), .BUBBLE_VALUE(37'h0)) dut37 (
        .i_clk(clk), .i_rst(rst_n), .i_flush(flush37), .bus(if37), .o_count(cnt37)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of stored entries plus the acceptance flag the stage advertises.
    logic [63:0] mq[$];
    bit m_ready = 1'b0;
    bit m_last_in_fire = 1'b0;
    bit m_last_flush = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit iv, orr, fl, of, inf;
        logic [63:0] d;
        if (!rst_n) begin
            mq.delete();
            m_ready = 1'b0;
            m_last_in_fire = 1'b0;
            m_last_flush = 1'b0;
        end else begin
            if (sel37) begin
                iv = if37.in_valid; orr = if37.out_ready; fl = flush37; d = 64'(if37.in_data);
            end else begin
                iv = if8.in_valid;  orr = if8.out_ready;  fl = flush8;  d = 64'(if8.in_data);
            end
            of  = (mq.size() > 0) && orr;
            inf = iv && m_ready;
            if (of) void'(mq.pop_front());
            if (inf) mq.push_back(d);
            if (fl) mq.delete();
            m_ready = (mq.size() < 2);
            m_last_in_fire = inf;
            m_last_flush = fl;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag);
        logic [63:0] ov, od, oc, ordy, ed;
        if (sel37) begin
            ov = 64'(if37.out_valid); od = 64'(if37.out_data); oc = 64'(cnt37); ordy = 64'(if37.in_ready);
            ed = (mq.size() > 0) ? mq[0] : 64'd0;
        end else begin
            ov = 64'(if8.out_valid); od = 64'(if8.out_data); oc = 64'(cnt8); ordy = 64'(if8.in_ready);
            ed = (mq.size() > 0) ? mq[0] : 64'hA5;
        end
        chk({tag, ".out_valid"}, ov, 64'(mq.size() > 0));
        chk({tag, ".out_data"}, od, ed);
        chk({tag, ".count"}, oc, 64'(mq.size()));
        chk({tag, ".in_ready"}, ordy, 64'(m_ready));
    endtask

    // driver: check current outputs at the falling edge, then drive the next cycle's inputs
    task automatic cyc8(input string tag, input bit iv, input logic [7:0] d, input bit orr, input bit fl);
        @(negedge clk);
        check_cycle(tag);
        if8.in_valid = iv;
        if8.in_data = d;
        if8.out_ready = orr;
        flush8 = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        sel37 = 1'b0;
        flush8 = 1'b0; flush37 = 1'b0;
        if8.in_valid = 1'b0; if8.in_data = '0; if8.out_ready = 1'b0;
        if37.in_valid = 1'b0; if37.in_data = '0; if37.out_ready = 1'b0;

        // reset / bubble
        repeat (3) @(negedge clk);
        chk("rst.out_valid", 64'(if8.out_valid), 64'd0);
        chk("rst.out_data", 64'(if8.out_data), 64'hA5);
        chk("rst.in_ready", 64'(if8.in_ready), 64'd0);
        chk("rst.count", 64'(cnt8), 64'd0);
        rst_n = 1'b1;
        cyc8("post_rst", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst.in_ready_hi", 64'(if8.in_ready), 64'd1);

        // streaming
        for (int i = 1; i <= 4; i++) begin
            cyc8("stream", 1'b1, 8'(i), 1'b1, 1'b0);
            if (i > 1) begin
                chk("stream.count1", 64'(cnt8), 64'd1);
                chk("stream.data", 64'(if8.out_data), 64'(i - 1));
            end
        end
        cyc8("stream_end", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("stream.last", 64'(if8.out_data), 64'h04);
        cyc8("stream_idle", 1'b0, 8'h00, 1'b1, 1'b0);

        // backpressure fill and drain
        cyc8("bp", 1'b1, 8'h10, 1'b0, 1'b0);
        cyc8("bp", 1'b1, 8'h11, 1'b0, 1'b0);
        cyc8("bp_full", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("bp.count2", 64'(cnt8), 64'd2);
        chk("bp.in_ready0", 64'(if8.in_ready), 64'd0);
        chk("bp.head", 64'(if8.out_data), 64'h10);
        cyc8("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        cyc8("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain.second", 64'(if8.out_data), 64'h11);
        chk("drain.in_ready_back", 64'(if8.in_ready), 64'd1);
        cyc8("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain.empty", 64'(if8.out_valid), 64'd0);

        // flush in TWO with a simultaneous offer that must be discarded
        cyc8("fl_fill", 1'b1, 8'h20, 1'b0, 1'b0);
        cyc8("fl_fill", 1'b1, 8'h21, 1'b0, 1'b0);
        cyc8("fl_pulse", 1'b1, 8'h77, 1'b0, 1'b1);
        cyc8("fl_after", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush.count0", 64'(cnt8), 64'd0);
        chk("flush.bubble", 64'(if8.out_data), 64'hA5);
        for (int i = 0; i < 3; i++) begin
            cyc8("fl_idle", 1'b0, 8'h00, 1'b1, 1'b0);
            chk("flush.no77", 64'(if8.out_data == 8'h77), 64'd0);
        end

        // asynchronous reset mid-stream
        cyc8("ar_fill", 1'b1, 8'h30, 1'b0, 1'b0);
        cyc8("ar_fill", 1'b1, 8'h31, 1'b0, 1'b0);
        cyc8("ar_full", 1'b0, 8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 64'(if8.out_valid), 64'd0);
        chk("arst.count", 64'(cnt8), 64'd0);
        chk("arst.out_data", 64'(if8.out_data), 64'hA5);
        @(negedge clk);
        check_cycle("arst_hold");
        rst_n = 1'b1;
        if8.in_valid = 1'b1; if8.in_data = 8'h40; if8.out_ready = 1'b1;
        cyc8("arst_rel", 1'b1, 8'h40, 1'b1, 1'b0);
        cyc8("arst_first", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("arst.first_out", 64'(if8.out_data), 64'h40);
        chk("arst.first_valid", 64'(if8.out_valid), 64'd1);
        cyc8("arst_end", 1'b0, 8'h00, 1'b1, 1'b0);

        // random soak on the 37-bit instance, fresh reset first
        @(negedge clk);
        if8.in_valid = 1'b0;
        rst_n = 1'b0;
        sel37 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            check_cycle("soak");
            if (!(if37.in_valid && !m_last_in_fire && !m_last_flush)) begin
                if37.in_valid = ($urandom_range(0, 3) != 0);
                if37.in_data = {5'($urandom), 32'($urandom)};
            end
            if37.out_ready = ($urandom_range(0, 3) != 0);
            flush37 = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        check_cycle("soak_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
